// File: rtl/div_seq_if.sv
// Ex <-> divider handshake bundle: operands, start/cancel request, result/ready/stall reply.
interface div_seq_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               signed_div_i;
  logic               start_i;
  logic               cancel_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;
  logic               stallreq_o;

  modport master (
    output opdata1_i, opdata2_i, signed_div_i, start_i, cancel_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  opdata1_i, opdata2_i, signed_div_i, start_i, cancel_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div_seq.sv
// Radix-2 restoring divider sequencer for Ex div/mod, one quotient bit per cycle.
// Optional DIV_EARLY_OUT_EN: |dividend| < |divisor| skips the iteration and finishes in END directly.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_ON, S_END} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   dvd, rem, dvs;
  logic               neg_q, neg_r;
  logic [2*WIDTH-1:0] res;

  logic               sgn1, sgn2, accept, early_out, last, ge;
  logic [WIDTH-1:0]   mag1, mag2, rem_step, dvd_step;
  logic [WIDTH:0]     trial;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic neg);
    logic signed [WIDTH-1:0] s;
    s = v;
    return neg ? -s : s;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v, input logic neg);
    logic signed [WIDTH-1:0] s;
    s = v;
    return neg ? -s : s;
  endfunction

  assign sgn1   = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
  assign sgn2   = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
  assign mag1   = mag(bus.opdata1_i, sgn1);
  assign mag2   = mag(bus.opdata2_i, sgn2);
  assign accept = bus.start_i & ~bus.cancel_i;

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (mag1 < mag2);
`else
  assign early_out = 1'b0;
`endif

  // Restoring step: the subtraction result always fits WIDTH bits when taken.
  assign trial    = {rem, dvd[WIDTH-1]};
  assign ge       = (trial >= {1'b0, dvs});
  assign rem_step = ge ? (trial[WIDTH-1:0] - dvs) : trial[WIDTH-1:0];
  assign dvd_step = {dvd[WIDTH-2:0], ge};
  assign last     = (cnt == CW'(WIDTH - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (bus.opdata2_i == '0) state_nxt = S_DIVZERO;
          else if (early_out)      state_nxt = S_END;
          else                     state_nxt = S_ON;
        end
      end
      S_DIVZERO: state_nxt = bus.cancel_i ? S_IDLE : S_END;
      S_ON: begin
        if (bus.cancel_i) state_nxt = S_IDLE;
        else if (last)    state_nxt = S_END;
      end
      S_END:   if (bus.cancel_i || !bus.start_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      dvd   <= '0;
      rem   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      res   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            cnt   <= '0;
            rem   <= '0;
            dvd   <= mag1;
            dvs   <= mag2;
            neg_q <= sgn1 ^ sgn2;
            neg_r <= sgn1;
            res   <= (early_out && bus.opdata2_i != '0) ? {bus.opdata1_i, {WIDTH{1'b0}}} : '0;
          end
        end
        S_DIVZERO: res <= '0;
        S_ON: begin
          rem <= rem_step;
          dvd <= dvd_step;
          cnt <= cnt + CW'(1);
          if (last) res <= {apply_sign(rem_step, neg_r), apply_sign(dvd_step, neg_q)};
        end
        default: ;
      endcase
    end
  end

  assign bus.ready_o    = (state == S_END);
  assign bus.result_o   = (state == S_END) ? res : '0;
  assign bus.stallreq_o = bus.start_i & ~bus.ready_o & ~bus.cancel_i;

endmodule
